mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. Sits between `mips_pipeline` and the unified memory. It serialises the two accesses of each pipeline slot with data-first priority and returns captured read data. It drives one global stall that freezes the whole pipeline until every access requested in the current slot has completed.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `CNT_W`, 32, width of stall-cycle counter

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `inst_adr`  in  ADDR_W  fetch address from pipeline; fetch requested every slot
- `inst`  out  DATA_W  captured instruction word
- `data_adr`  in  ADDR_W  data address from MEM stage
- `data_out`  in  DATA_W  store data from MEM stage
- `mem_read`, `mem_write`  in  1  MEM-stage load / store request
- `data_in`  out  DATA_W  captured load data
- `stall`  out  1  freeze PC and all pipeline registers
- `m_req`  out  1  memory request, held until accepted
- `m_we`  out  1  write enable for current request
- `m_adr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory read data, valid with `m_ready`
- `m_ready`  in  1  memory completes current request this cycle
- `stall_cnt`  out  CNT_W  cycles with `stall`=1 since reset, saturating

## Operation
- States: `IDLE`, `BUSY_D`, `BUSY_I`. Flags `d_done`, `i_done` record completions within the current slot.
- Data request `d_req` = `mem_read | mem_write`. Both high is treated as a write.
- `stall` = `~i_done | (d_req & ~d_done)`. It is combinational from the flags and the inputs.
- IDLE transitions:
  - If `d_req & ~d_done`: load `m_adr`=`data_adr`, `m_wdata`=`data_out`, `m_we`=`mem_write`; go to `BUSY_D`.
  - Else if `~i_done`: load `m_adr`=`inst_adr`, `m_we`=0; go to `BUSY_I`.
  - Else stay in `IDLE`.
- In `BUSY_x`, `m_req`=1 and the registered address, data and write enable are held stable.
- On `m_ready`=1 in `BUSY_x`:
  - Set `x_done`.
  - Read in `BUSY_I`: capture `m_rdata` into `inst`.
  - Read in `BUSY_D`: capture `m_rdata` into `data_in`.
  - Write: `data_in` is left unchanged.
  - Return to `IDLE`.
- At any edge with `stall`=0, both flags clear. The pipeline advances on that same edge.
- `inst` and `data_in` hold their captured values until the next capture.
- The pipeline holds `inst_adr`, `data_adr`, `data_out`, `mem_read` and `mem_write` stable while `stall`=1. The bench checks this with an assertion; the RTL does not check it.
- `stall_cnt` increments on every edge where `stall`=1 and saturates at all-ones.

## Timing
- Reset values: state `IDLE`, both flags 0, `m_req`=0, `m_we`=0, `m_adr`=0, `m_wdata`=0, `inst`=0 (decodes as a nop), `data_in`=0, `stall_cnt`=0. `stall` is 1 after reset because a fetch is pending.
- Fetch-only slot, zero-wait memory:
  - Cycle 0: `IDLE`, issue.
  - Cycle 1: `m_req`=1, `m_ready`=1.
  - Cycle 2: `IDLE`, `stall`=0; the pipeline advances at the end of cycle 2.
  - Total: 3 cycles per slot.
- Load or store slot: data access first, then fetch. Total is 5 cycles at zero wait.
- Each memory wait cycle adds 1 cycle to the slot.
- `m_req` never drops before `m_ready`. There is no idle cycle between `m_ready` and the next `IDLE` decision.
- Request arrives while in `BUSY_I`: serviced after the fetch completes. No preemption.
- Reset mid-transaction: `m_req` drops asynchronously and the transaction is abandoned. The memory tolerates this.
- `m_ready` while `IDLE`: ignored.

## Structure
- Shared package `mips_pkg` holds:
  - The `arb_state_t` enum (`IDLE`, `BUSY_D`, `BUSY_I`).
  - Default width constants `ADDR_W` and `DATA_W`.
- Single module. No sub-module is required.
- The saturating counter may be instantiated as `sat_counter` if that block already exists in the library.

## Test plan
- Reset released, memory zero-wait, `inst_adr`=0x00, `m_rdata`=0x20080005 → `m_adr`=0x00 with `m_req` in cycle 1; `inst`=0x20080005 and `stall`=0 in cycle 2.
- `mem_read`=1, `data_adr`=0x40, `inst_adr`=0x04 in the same slot:
  - Data issued first (`m_adr`=0x40), then fetch (`m_adr`=0x04).
  - `stall`=0 only in cycle 4.
  - `data_in` and `inst` hold the two read values.
- `mem_write`=1, `data_adr`=0x80, `data_out`=0xDEADBEEF → `m_we`=1 with those values; `data_in` unchanged.
- Memory inserts 3 wait cycles on a fetch → `m_req`, `m_adr` stable for 4 cycles; the slot lasts 6 cycles; `stall_cnt` increases by 5.
- `rst` asserted while in `BUSY_D` with `m_req`=1 → `m_req`=0 immediately, all outputs at reset values; after release, the fetch restarts at `inst_adr`.
- `mem_read`=`mem_write`=1 → treated as a write (`m_we`=1).

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and default widths for the MIPS pipeline and
//               its memory arbiter.
//               - arb_state_t : arbiter FSM states (IDLE, BUSY_D, BUSY_I)
//               - ADDR_W      : default address width
//               - DATA_W      : default data width
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported, variable-latency memory between the
//               instruction-fetch port and the MEM-stage data port. Within a
//               pipeline slot the data access (if any) goes first, then the
//               fetch. A global stall holds the pipeline until every access of
//               the slot has completed.
// Ports       : clk, rst (async, active-low)
//               inst_adr / inst            - fetch address, captured word
//               data_adr / data_out        - load/store address, store data
//               mem_read / mem_write       - MEM-stage request (both = write)
//               data_in                    - captured load data
//               stall                      - freeze PC and pipeline registers
//               m_req/m_we/m_adr/m_wdata   - memory request side
//               m_rdata/m_ready            - memory response side
//               stall_cnt                  - saturating stalled-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W = mips_pkg::ADDR_W,
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_adr,
    output logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] data_out,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] data_in,
    output logic              stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_adr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_d_done;
    logic              r_i_done;
    logic [ADDR_W-1:0] r_m_adr;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_m_we;
    logic [DATA_W-1:0] r_inst;
    logic [DATA_W-1:0] r_data_in;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_d_req;
    logic              w_stall;
    logic              w_load_d;
    logic              w_load_i;
    logic              w_done_d;
    logic              w_done_i;

    // A simultaneous load+store request is serviced as a store: m_we is
    // loaded straight from mem_write.
    assign w_d_req = mem_read | mem_write;
    assign w_stall = ~r_i_done | (w_d_req & ~r_d_done);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and control decode. m_ready is only honoured in the
    // BUSY states, so a stray m_ready while IDLE has no effect.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load_d    = 1'b0;
        w_load_i    = 1'b0;
        w_done_d    = 1'b0;
        w_done_i    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_d_req && !r_d_done) begin
                    w_state_nxt = BUSY_D;
                    w_load_d    = 1'b1;
                end else if (!r_i_done) begin
                    w_state_nxt = BUSY_I;
                    w_load_i    = 1'b1;
                end
            end
            BUSY_D: begin
                if (m_ready) begin
                    w_state_nxt = IDLE;
                    w_done_d    = 1'b1;
                end
            end
            BUSY_I: begin
                if (m_ready) begin
                    w_state_nxt = IDLE;
                    w_done_i    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-slot completion flags. stall can only be low in IDLE with both
    // accesses finished, so clearing never races with a completion.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
        end else if (!w_stall) begin
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
        end else begin
            if (w_done_d) begin
                r_d_done <= 1'b1;
            end
            if (w_done_i) begin
                r_i_done <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory request registers: loaded on issue, held while busy. The write
    // data register keeps its old value across fetches.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m_adr   <= '0;
            r_m_wdata <= '0;
            r_m_we    <= 1'b0;
        end else if (w_load_d) begin
            r_m_adr   <= data_adr;
            r_m_wdata <= data_out;
            r_m_we    <= mem_write;
        end else if (w_load_i) begin
            r_m_adr   <= inst_adr;
            r_m_we    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Read-data capture. A completed store leaves data_in untouched.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst    <= '0;
            r_data_in <= '0;
        end else begin
            if (w_done_i) begin
                r_inst <= m_rdata;
            end
            if (w_done_d && !r_m_we) begin
                r_data_in <= m_rdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturating stalled-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign stall     = w_stall;
    assign m_req     = (r_state != IDLE);
    assign m_we      = r_m_we;
    assign m_adr     = r_m_adr;
    assign m_wdata   = r_m_wdata;
    assign inst      = r_inst;
    assign data_in   = r_data_in;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A small memory model with
//               a configurable wait count answers requests; pipeline slots are
//               driven from a table of directed vectors with hand-computed
//               expectations, followed by hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mips_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] inst_adr  = '0;
    logic [DW-1:0] inst;
    logic [AW-1:0] data_adr  = '0;
    logic [DW-1:0] data_out  = '0;
    logic          mem_read  = 1'b0;
    logic          mem_write = 1'b0;
    logic [DW-1:0] data_in;
    logic          stall;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata   = '0;
    logic          m_ready   = 1'b0;
    logic [CW-1:0] stall_cnt;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .inst_adr  (inst_adr),
        .inst      (inst),
        .data_adr  (data_adr),
        .data_out  (data_out),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_in   (data_in),
        .stall     (stall),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_adr     (m_adr),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // ------------------------------------------------------------------------
    // Memory model
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    logic [31:0] mem [0:63];
    int          cfg_waits         = 0;
    int          wait_cnt          = 0;
    bit          inject_idle_ready = 1'b0;
    logic [31:0] held_adr          = '0;
    logic        held_we           = 1'b0;
    txn_t        log_q[$];
    txn_t        mon_t;

    always @(negedge clk) begin
        if (m_req) begin
            if (wait_cnt == 0) begin
                held_adr = m_adr;
                held_we  = m_we;
            end else begin
                tests++;
                if (m_adr !== held_adr || m_we !== held_we) begin
                    fails++;
                    $display("FAIL req_hold: adr=%h we=%b required adr=%h we=%b",
                             m_adr, m_we, held_adr, held_we);
                end
            end
            if (wait_cnt >= cfg_waits) begin
                m_ready = 1'b1;
                m_rdata = mem[m_adr[7:2]];
                if (m_we) begin
                    mem[m_adr[7:2]] = m_wdata;
                end
                mon_t.adr   = m_adr;
                mon_t.we    = m_we;
                mon_t.wdata = m_wdata;
                log_q.push_back(mon_t);
                wait_cnt = 0;
            end else begin
                m_ready = 1'b0;
                m_rdata = 32'hBAD0BAD0;
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            m_ready  = inject_idle_ready;
            m_rdata  = inject_idle_ready ? 32'hFFFFFFFF : 32'h0;
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline-side contract: request inputs stay put across a stalled edge.
    // ------------------------------------------------------------------------
    logic [31:0] p_ia = '0, p_da = '0, p_do = '0;
    logic        p_rd = 1'b0, p_wr = 1'b0, p_stall = 1'b0, p_rst = 1'b0;

    always @(negedge clk) begin
        #3;
        if (rst && p_rst && p_stall) begin
            assert (inst_adr === p_ia && data_adr === p_da && data_out === p_do &&
                    mem_read === p_rd && mem_write === p_wr)
            else begin
                fails++;
                $display("FAIL input_stable: inputs changed while stalled");
            end
        end
        p_ia    = inst_adr;
        p_da    = data_adr;
        p_do    = data_out;
        p_rd    = mem_read;
        p_wr    = mem_write;
        p_stall = stall;
        p_rst   = rst;
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] dout;
        logic        rd;
        logic        wr;
        int          waits;
        int          cyc;
        int          ntx;
        logic [31:0] adr0;
        logic        we0;
        logic [31:0] wd0;
        logic [31:0] adr1;
        logic [31:0] exp_inst;
        logic [31:0] exp_din;
    } vec_t;

    // Called at the negedge of slot cycle 0; returns at the negedge of the
    // next slot's cycle 0.
    task automatic run_slot(input vec_t v, input string tag);
        logic [31:0] s0;
        int          cyc;
        inst_adr  = v.ia;
        data_adr  = v.da;
        data_out  = v.dout;
        mem_read  = v.rd;
        mem_write = v.wr;
        cfg_waits = v.waits;
        log_q.delete();
        #1;
        s0  = stall_cnt;
        cyc = 1;
        while (stall !== 1'b0 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 64) begin
            $display("FAIL %s_timeout: stall still %b after %0d cycles", tag, stall, cyc);
        end
        chk({tag, "_cycles"}, cyc, v.cyc);
        chk({tag, "_stall_cnt_delta"}, stall_cnt - s0, v.cyc - 1);
        chk({tag, "_inst"}, inst, v.exp_inst);
        chk({tag, "_data_in"}, data_in, v.exp_din);
        chk({tag, "_idle_req"}, m_req, 1'b0);
        chk({tag, "_ntx"}, log_q.size(), v.ntx);
        if (log_q.size() >= 1) begin
            chk({tag, "_adr0"}, log_q[0].adr, v.adr0);
            chk({tag, "_we0"}, log_q[0].we, v.we0);
            if (v.we0) begin
                chk({tag, "_wdata0"}, log_q[0].wdata, v.wd0);
            end
        end
        if (log_q.size() >= 2 && v.ntx == 2) begin
            chk({tag, "_adr1"}, log_q[1].adr, v.adr1);
            chk({tag, "_we1"}, log_q[1].we, 1'b0);
        end
        @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h00] = 32'h20080005;   // 0x00
        mem[6'h01] = 32'h8C090040;   // 0x04
        mem[6'h02] = 32'hAC0A0080;   // 0x08
        mem[6'h03] = 32'h01095020;   // 0x0C
        mem[6'h04] = 32'h11112222;   // 0x10
        mem[6'h05] = 32'h33334444;   // 0x14
        mem[6'h10] = 32'h12345678;   // 0x40
        mem[6'h20] = 32'h0BADF00D;   // 0x80
        mem[6'h30] = 32'hCAFEF00D;   // 0xC0

        //          ia     da     dout          rd wr wt cyc ntx adr0   we0 wd0           adr1   inst          data_in
        vecs[0] = '{32'h00, 32'h00, 32'h0,        0, 0, 0, 3, 1, 32'h00, 0, 32'h0,        32'h00, 32'h20080005, 32'h00000000};
        vecs[1] = '{32'h04, 32'h40, 32'h0,        1, 0, 0, 5, 2, 32'h40, 0, 32'h0,        32'h04, 32'h8C090040, 32'h12345678};
        vecs[2] = '{32'h08, 32'h80, 32'hDEADBEEF, 0, 1, 0, 5, 2, 32'h80, 1, 32'hDEADBEEF, 32'h08, 32'hAC0A0080, 32'h12345678};
        vecs[3] = '{32'h0C, 32'h00, 32'h0,        0, 0, 3, 6, 1, 32'h0C, 0, 32'h0,        32'h00, 32'h01095020, 32'h12345678};
        vecs[4] = '{32'h10, 32'h80, 32'h0,        1, 0, 0, 5, 2, 32'h80, 0, 32'h0,        32'h10, 32'h11112222, 32'hDEADBEEF};
        vecs[5] = '{32'h14, 32'hC0, 32'h55AA55AA, 1, 1, 0, 5, 2, 32'hC0, 1, 32'h55AA55AA, 32'h14, 32'h33334444, 32'hDEADBEEF};
        vecs[6] = '{32'h00, 32'hC0, 32'h0,        1, 0, 1, 7, 2, 32'hC0, 0, 32'h0,        32'h00, 32'h20080005, 32'h55AA55AA};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 1'b1);
        chk("rst_m_req", m_req, 1'b0);
        chk("rst_m_we", m_we, 1'b0);
        chk("rst_m_adr", m_adr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_data_in", data_in, 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        rst = 1'b1;

        // Directed slots
        for (int i = 0; i < 7; i++) begin
            run_slot(vecs[i], $sformatf("vec%0d", i));
        end

        // Stray m_ready while IDLE must not complete anything
        inject_idle_ready = 1'b1;
        run_slot('{32'h04, 32'h00, 32'h0, 0, 0, 0, 3, 1, 32'h04, 0, 32'h0, 32'h00,
                   32'h8C090040, 32'h55AA55AA}, "idle_ready");
        inject_idle_ready = 1'b0;

        // Reset in the middle of a data access
        cfg_waits = 5;
        inst_adr  = 32'h08;
        data_adr  = 32'h40;
        data_out  = 32'h0;
        mem_read  = 1'b1;
        mem_write = 1'b0;
        @(negedge clk);
        chk("mid_busy_m_req", m_req, 1'b1);
        chk("mid_busy_m_adr", m_adr, 32'h40);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_m_req", m_req, 1'b0);
        chk("mid_rst_m_adr", m_adr, 32'h0);
        chk("mid_rst_m_we", m_we, 1'b0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_data_in", data_in, 32'h0);
        chk("mid_rst_stall_cnt", stall_cnt, 32'h0);
        chk("mid_rst_stall", stall, 1'b1);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_slot('{32'h08, 32'h40, 32'h0, 0, 0, 0, 3, 1, 32'h08, 0, 32'h0, 32'h00,
                   32'hAC0A0080, 32'h00000000}, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
